dmem_ctrl: RTL and testbench

Data-memory controller sitting directly downstream of the load/store unit. It accepts one word-sized load or store request per transaction through a request/grant handshake, holds it for a fixed access latency, commits stores, and returns load data with a one-cycle valid pulse. Misaligned and out-of-range accesses complete with an error flag and have no side effect. It models the DRAM port that supplies the LSU's grant and load data.

---
 rtl/dmem_ctrl.sv | 150 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
//
// Data-memory controller placed directly downstream of the load/store unit.
// It accepts one word-sized load or store per transaction through a
// request/grant handshake, holds it for LATENCY busy cycles, commits stores
// and returns load data with a one-cycle valid pulse. Misaligned and
// out-of-range accesses complete with an error flag and have no side effect.
//
// Parameters:
//   DEPTH_WORDS   number of 32-bit words in the backing array (power of two)
//   LATENCY       BUSY cycles between accept and response (1..15)
//
// Ports:
//   clock          single clock, all state updates on the rising edge
//   reset          asynchronous, active-high reset
//   data_req_i     request from the LSU
//   data_we_i      1 = store, 0 = load (sampled at accept)
//   data_addr_i    byte address (sampled at accept)
//   data_wdata_i   store data (sampled at accept)
//   data_gnt_o     request accepted this cycle (combinational)
//   data_rvalid_o  response valid, registered one-cycle pulse
//   data_rdata_o   load data, held until the next response
//   data_err_o     error flag, meaningful only with data_rvalid_o
//   busy_o         high while a transaction is in BUSY or RESP
// ---------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_cnt;
    logic           r_we;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic           r_rvalid;
    logic           r_err;
    logic [31:0]    r_rdata;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_accept;
    logic           w_done;
    logic           w_err;
    logic [AW-1:0]  w_idx;

    // Grant is gated by reset so that a request held through reset is never
    // seen as accepted.
    assign w_accept = (r_state == S_IDLE) && data_req_i && !reset;

    // Last BUSY cycle: the following edge is the commit/response edge.
    assign w_done   = (r_state == S_BUSY) && (r_cnt == 4'd0);

    // Index and error come from the latched address, so input changes after
    // accept cannot disturb the transaction in flight.
    assign w_idx    = r_addr[AW+1:2];
    assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr[31:AW+2] != '0);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture and latency counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_cnt   <= 4'(LATENCY - 1);
            r_we    <= data_we_i;
            r_addr  <= data_addr_i;
            r_wdata <= data_wdata_i;
        end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Response registers. rdata only changes on a response edge, so it holds
    // the last response's value in between.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_rvalid <= w_done;
            r_err    <= w_done && w_err;
            if (w_done) begin
                r_rdata <= (!w_err && !r_we) ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // NOTE: the backing array is deliberately not reset; it maps onto plain
    // RAM. A reset during BUSY forces the state to IDLE asynchronously, so
    // w_done is low at the next edge and a pending store is dropped.
    always_ff @(posedge clock) begin
        if (w_done && r_we && !w_err) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign data_gnt_o    = w_accept;
    assign data_rvalid_o = r_rvalid;
    assign data_rdata_o  = r_rdata;
    assign data_err_o    = r_err;
    assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl
//
// Self-checking bench for dmem_ctrl. Instance dut_a (LATENCY=2) carries the
// transaction tests through a scoreboard: the expected response (data, error,
// arrival cycle) is pushed when a request is granted and popped when
// data_rvalid_o is seen. Instance dut_b (LATENCY=1) checks the grant cadence
// with the request held high.
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic        clock = 1'b0;
    logic        reset;

    logic        req_a, we_a;
    logic [31:0] addr_a, wdata_a;
    logic        gnt_a, rvalid_a, err_a, busy_a;
    logic [31:0] rdata_a;

    logic        req_b, we_b;
    logic [31:0] addr_b, wdata_b;
    logic        gnt_b, rvalid_b, err_b, busy_b;
    logic [31:0] rdata_b;

    always #5 clock = ~clock;

    dmem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) dut_a (
        .clock         (clock),
        .reset         (reset),
        .data_req_i    (req_a),
        .data_we_i     (we_a),
        .data_addr_i   (addr_a),
        .data_wdata_i  (wdata_a),
        .data_gnt_o    (gnt_a),
        .data_rvalid_o (rvalid_a),
        .data_rdata_o  (rdata_a),
        .data_err_o    (err_a),
        .busy_o        (busy_a)
    );

    dmem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(LAT_B)) dut_b (
        .clock         (clock),
        .reset         (reset),
        .data_req_i    (req_b),
        .data_we_i     (we_b),
        .data_addr_i   (addr_b),
        .data_wdata_i  (wdata_b),
        .data_gnt_o    (gnt_b),
        .data_rvalid_o (rvalid_b),
        .data_rdata_o  (rdata_b),
        .data_err_o    (err_b),
        .busy_o        (busy_b)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [int];
    int          cyc    = 0;
    int          n_vec  = 0;
    int          n_bad  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor for dut_a.
    always @(negedge clock) begin
        if (!reset && rvalid_a) begin
            if (sb.size() == 0) begin
                check("spurious_rvalid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_cycle", cyc, mon_e.due);
                check("resp_err", {31'd0, err_a}, {31'd0, mon_e.err});
                if (mon_e.chk_data) check("resp_rdata", rdata_a, mon_e.rdata);
            end
        end
    end

    // One transaction on dut_a: drive, wait for grant, push expectation,
    // scramble inputs during BUSY, wait for the scoreboard to drain.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        logic bad;
        int   t;
        @(posedge clock);
        #1;
        req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
        @(negedge clock);
        t = 0;
        while (!gnt_a && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (!gnt_a) begin
            check("gnt_timeout", 32'd0, 32'd1);
            req_a = 1'b0;
            return;
        end
        bad        = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
        idx        = int'(a[11:2]);
        e.due      = cyc + LAT_A + 1;
        e.err      = bad;
        e.chk_data = 1'b1;
        e.rdata    = 32'd0;
        if (!bad && w) begin
            ref_mem[idx] = d;
        end else if (!bad && !w) begin
            if (ref_mem.exists(idx)) e.rdata = ref_mem[idx];
            else e.chk_data = 1'b0;
        end
        sb.push_back(e);
        @(posedge clock);
        #1;
        req_a = 1'b0; we_a = ~w; addr_a = a ^ 32'h0000_0F04; wdata_a = ~d;
        @(negedge clock);
        check("busy_in_busy", {31'd0, busy_a}, 32'd1);
        check("no_gnt_in_busy", {31'd0, gnt_a}, 32'd0);
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clock);
            t++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'd0; wdata_a = 32'd0;
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'd0; wdata_b = 32'd0;
        #2;
        // Reset state, including grant suppressed while a request is pending.
        check("rst_gnt_a",    {31'd0, gnt_a},    32'd0);
        check("rst_rvalid_a", {31'd0, rvalid_a}, 32'd0);
        check("rst_rdata_a",  rdata_a,           32'd0);
        check("rst_err_a",    {31'd0, err_a},    32'd0);
        check("rst_busy_a",   {31'd0, busy_a},   32'd0);
        check("rst_gnt_b",    {31'd0, gnt_b},    32'd0);
        check("rst_busy_b",   {31'd0, busy_b},   32'd0);
        req_a = 1'b0; req_b = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Store then load.
        do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h0000_0010, 32'd0);

        // Misaligned load, then the aligned word is intact.
        do_req(1'b0, 32'h0000_0013, 32'd0);
        do_req(1'b0, 32'h0000_0010, 32'd0);

        // Out-of-range store must not alias onto word 0.
        do_req(1'b1, 32'h0000_0000, 32'hCAFE_F00D);
        do_req(1'b1, 32'h0000_1000, 32'h1234_5678);
        do_req(1'b0, 32'h0000_0000, 32'd0);
        do_req(1'b0, 32'h8000_0004, 32'd0);

        // A few random words: store then read back.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra;
            logic [31:0] rd;
            ra = {20'd0, 10'($urandom_range(64, 1023)), 2'b00};
            rd = $urandom();
            do_req(1'b1, ra, rd);
            do_req(1'b0, ra, 32'd0);
        end

        // Reset in the middle of a store.
        do_req(1'b1, 32'h0000_0020, 32'h1111_1111);
        do_req(1'b0, 32'h0000_0020, 32'd0);
        @(posedge clock);
        #1;
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h0000_0020; wdata_a = 32'hA5A5_A5A5;
        @(negedge clock);
        check("midrst_gnt", {31'd0, gnt_a}, 32'd1);
        @(posedge clock);
        #1;
        req_a = 1'b0;
        check("midrst_busy_before", {31'd0, busy_a}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy",   {31'd0, busy_a},   32'd0);
        check("midrst_rvalid", {31'd0, rvalid_a}, 32'd0);
        check("midrst_rdata",  rdata_a,           32'd0);
        check("midrst_err",    {31'd0, err_a},    32'd0);
        check("midrst_gnt0",   {31'd0, gnt_a},    32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        do_req(1'b0, 32'h0000_0020, 32'd0);

        // Back-to-back on dut_b: request held high for 20 cycles.
        @(posedge clock);
        #1;
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'h0000_0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check($sformatf("b2b_gnt_%0d", i), {31'd0, gnt_b},
                  (i % (LAT_B + 2) == 0) ? 32'd1 : 32'd0);
            check($sformatf("b2b_rvalid_%0d", i), {31'd0, rvalid_b},
                  (i >= LAT_B + 1 && (i - LAT_B - 1) % (LAT_B + 2) == 0) ? 32'd1 : 32'd0);
            if (rvalid_b) check($sformatf("b2b_err_%0d", i), {31'd0, err_b}, 32'd0);
        end
        @(posedge clock);
        #1;
        req_b = 1'b0;

        repeat (6) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
